stream_feeder: RTL and testbench

STREAM_FEEDER -- requirements
Module: stream_feeder

---
 rtl/stream_feeder.sv | 143 ++++++++++++++
 tb/tb_stream_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_feeder.sv
// stream_feeder: reads a contiguous, wrapping BRAM address range and streams the words
// out in address order through a 2-entry buffer under valid/ready flow control.
module stream_feeder #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] interface_out,
    output logic              output_vld,
    input  logic              input_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            cur;
    state_t            nxt;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_rem;
    logic [ADDR_W:0]   snd_rem;
    logic              vld_p1;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              fifo_pop;
    logic [2:0]        level;
    logic              room;
    logic              accept;
    logic              last_rd;
    logic              last_snd;

    // The word returning from BRAM this cycle is already visible at the output
    // (bypass), so it counts toward the two-word limit together with the FIFO.
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign output_vld = !fifo_empty || vld_p1;
    assign pop        = output_vld && input_ready;
    assign push       = vld_p1 && !(fifo_empty && pop);
    assign fifo_pop   = pop && !fifo_empty;
    assign level      = {1'b0, fifo_cnt} + {2'b00, vld_p1};
    assign room       = level < (3'd2 + {2'b00, pop});
    assign accept     = (cur == S_IDLE) && start;
    assign last_rd    = bram_en && (rd_rem == CNT_ONE);
    assign last_snd   = pop && (snd_rem == CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IDLE:  if (start && (word_count != '0)) nxt = S_RUN;
            S_RUN:   if (last_rd) nxt = S_DRAIN;
            S_DRAIN: if (last_snd) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (cur != S_IDLE);
        state         = cur;
        bram_en       = (cur == S_RUN) && (rd_rem != '0) && room;
        bram_addr     = rd_addr;
        interface_out = '0;
        if (!fifo_empty) begin
            interface_out = fifo_mem[rd_ptr];
        end else if (vld_p1) begin
            interface_out = bram_dout;
        end
    end

    // Stage p0 -> p1: read issue; vld_p1 marks BRAM data arriving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr  <= '0;
            rd_rem   <= '0;
            snd_rem  <= '0;
            vld_p1   <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
            done     <= 1'b0;
        end else begin
            vld_p1 <= bram_en;
            if (accept) begin
                rd_addr <= base_addr;
                rd_rem  <= word_count;
                snd_rem <= word_count;
            end else begin
                if (bram_en) begin
                    rd_addr <= rd_addr + ADDR_ONE;
                    rd_rem  <= rd_rem - CNT_ONE;
                end
                if (pop) begin
                    snd_rem <= snd_rem - CNT_ONE;
                end
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fifo_pop};
            done     <= (accept && (word_count == '0)) || ((cur == S_DRAIN) && last_snd);
        end
    end

    // Stage p1 -> p2: capture returning words the consumer did not take directly.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bram_dout;
        end
    end

endmodule

// File: tb/tb_stream_feeder.sv
// Self-checking bench for stream_feeder: BRAM model, expected-word queue built from the
// address range, and cycle-level timing/ordering checks on the stream.
module tb_stream_feeder;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] interface_out;
    logic              output_vld;
    logic              input_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [1:0]        state;

    stream_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .interface_out(interface_out), .output_vld(output_vld),
        .input_ready(input_ready), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous-read BRAM; output is scrambled when not enabled so stale data is caught.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
        else         bram_dout <= {8{$urandom}};
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs, n_reads, n_done, first_en, first_vld, last_hs, done_cyc, exp_base, exp_cnt;
    logic [DATA_W-1:0] exp_q [$];
    logic              stalled_prev;
    logic [DATA_W-1:0] held;
    logic [5:0]        st_seq;
    logic [1:0]        last_st;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic arm(input int base, input int cnt);
        exp_q.delete();
        for (int k = 0; k < cnt; k++) exp_q.push_back(mem[(base + k) % DEPTH]);
        exp_base = base; exp_cnt = cnt;
        hs = 0; n_reads = 0; n_done = 0;
        first_en = -1; first_vld = -1; last_hs = -1; done_cyc = -1;
        stalled_prev = 1'b0; st_seq = '0; last_st = state;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled_prev) begin
                check_val("hold_vld", output_vld, 1);
                check_val("hold_data", interface_out, held);
            end
            if (bram_en) begin
                if (first_en < 0) first_en = cyc;
                check_val("read_budget", n_reads < exp_cnt, 1);
                check_val("bram_addr", bram_addr, (exp_base + n_reads) % DEPTH);
                n_reads++;
            end
            if (output_vld && first_vld < 0) first_vld = cyc;
            if (output_vld && input_ready) begin
                if (exp_q.size() == 0) check_val("extra_word", 1, 0);
                else                   check_val("data", interface_out, exp_q.pop_front());
                hs++;
                last_hs = cyc;
            end
            if (bram_en) check_val("outstanding", (n_reads - hs) <= 2, 1);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (state != last_st) begin
                st_seq  = {st_seq[3:0], state};
                last_st = state;
            end
            stalled_prev = output_vld && !input_ready;
            held         = interface_out;
        end
    end

    // mode 0: ready held high; mode 1: random ready with a forced 5-cycle stall and a
    // start pulse issued while busy (with scrambled base/count) that must be ignored.
    task automatic run_xfer(input int base, input int cnt, input int mode);
        int k;
        int t0;
        arm(base, cnt);
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(base); word_count = (ADDR_W+1)'(cnt);
        input_ready = (mode == 0) ? 1'b1 : 1'($urandom);
        t0 = cyc;
        k  = 1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = ADDR_W'($urandom); word_count = (ADDR_W+1)'($urandom);
        while (n_done == 0 && k < cnt * 8 + 40) begin
            if (mode == 1) begin
                input_ready = (k >= 3 && k < 8) ? 1'b0 : 1'($urandom);
                start       = (k == 5) && busy;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_val("done_once", n_done, 1);
        check_val("words", hs, cnt);
        check_val("reads", n_reads, cnt);
        check_val("leftover", exp_q.size(), 0);
        check_val("end_state", state, 0);
        check_val("end_busy", busy, 0);
        if (cnt == 0) begin
            check_val("zero_no_en", first_en < 0, 1);
            check_val("zero_no_vld", first_vld < 0, 1);
            check_val("zero_done_lat", done_cyc - t0, 1);
            check_val("zero_state", st_seq, 0);
        end else begin
            check_val("first_en_lat", first_en - t0, 1);
            check_val("first_vld_lat", first_vld - t0, 2);
            check_val("done_after_last", done_cyc - last_hs, 1);
            if (mode == 0) begin
                check_val("complete_lat", last_hs - t0, cnt + 1);
                check_val("state_seq", st_seq, 6'b01_10_00);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_state"}, state, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_vld"}, output_vld, 0);
        check_val({tag, "_en"}, bram_en, 0);
        check_val({tag, "_addr"}, bram_addr, 0);
        check_val({tag, "_out"}, interface_out, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < 8; j++) mem[i][j*32 +: 32] = $urandom;
            mem[i][15:0] = 16'(i);
        end
        arm(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_xfer(0, 16, 0);
        run_xfer(2046, 4, 0);
        run_xfer(0, 8, 1);
        run_xfer(77, 0, 0);
        run_xfer(2047, 1, 0);

        // Abort after three words have been handshaken.
        arm(100, 10);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 11'd100; word_count = 12'd10; input_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (hs < 3 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("abort_reach", hs, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("abort_no_done", n_done, 0);
        check_val("abort_no_words", hs, 3);
        check_val("abort_idle", busy, 0);

        run_xfer(500, 2, 0);
        for (int r = 0; r < 3; r++) run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1);
        run_xfer(5, 2048, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
